// File: rtl/matrix_alu_engine.sv
// matrix_alu_engine: loads row-major operands through a fixed-latency read port, computes transpose/add/sub/scalar/element-wise/matmul, writes the result back.
module matrix_alu_engine #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int MAX_DIM = 5,
  parameter int RD_LAT = 2,
  localparam int DIM_W = $clog2(MAX_DIM + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [2:0]        i_op,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [ADDR_W-1:0] i_res_addr,
  input  logic [DIM_W-1:0]  i_a_m,
  input  logic [DIM_W-1:0]  i_a_n,
  input  logic [DIM_W-1:0]  i_b_m,
  input  logic [DIM_W-1:0]  i_b_n,
  input  logic [DATA_W-1:0] i_scalar,
  output logic              o_busy,
  output logic              o_done,
  output logic [1:0]        o_err,
  output logic [DIM_W-1:0]  o_res_m,
  output logic [DIM_W-1:0]  o_res_n,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [DATA_W-1:0] o_wdata
);
  localparam int NE = MAX_DIM * MAX_DIM;
  localparam int IW = $clog2(NE + 1);
  localparam int CW = $clog2(NE + RD_LAT + 1);
  localparam logic [DIM_W-1:0] MD = DIM_W'(MAX_DIM);
  localparam logic [CW-1:0] LAT = CW'(RD_LAT);

  typedef enum logic [2:0] {IDLE, CHECK, LOAD_A, LOAD_B, CALC, WRITE, DONE} state_t;

  state_t state;
  logic [2:0] op;
  logic [ADDR_W-1:0] a_base, b_base, r_base;
  logic [DIM_W-1:0] a_m, a_n, b_m, b_n, r, c, k;
  logic [DATA_W-1:0] scalar, acc;
  logic [CW-1:0] cnt;
  logic [RD_LAT-1:0] pv, ps;
  logic [IW-1:0] pi [RD_LAT];
  logic [DATA_W-1:0] a_buf [NE];
  logic [DATA_W-1:0] b_buf [NE];
  logic [DATA_W-1:0] res_buf [NE];

  logic uses_b, bad_dim, mism, store, last;
  logic [1:0] err;
  logic [DIM_W-1:0] rm, rn;
  logic [CW-1:0] n_a, n_b, n_r, n_cur;
  logic [ADDR_W-1:0] base;
  logic [IW-1:0] ridx, ai, bi;
  logic [DATA_W-1:0] av, bv, ew, store_val;

  always_comb begin
    uses_b = op == 3'd1 || op == 3'd3 || op == 3'd4 || op == 3'd5;
    bad_dim = a_m == '0 || a_m > MD || a_n == '0 || a_n > MD ||
              (uses_b && (b_m == '0 || b_m > MD || b_n == '0 || b_n > MD));
    mism = ((op == 3'd1 || op == 3'd4 || op == 3'd5) && (a_m != b_m || a_n != b_n)) ||
           (op == 3'd3 && a_n != b_m);
    err = op > 3'd5 ? 2'd1 : bad_dim ? 2'd2 : mism ? 2'd3 : 2'd0;
    rm = op == 3'd0 ? a_n : a_m;
    rn = op == 3'd0 ? a_m : op == 3'd3 ? b_n : a_n;
    n_a = CW'(a_m) * CW'(a_n);
    n_b = CW'(b_m) * CW'(b_n);
    n_r = CW'(rm) * CW'(rn);
    n_cur = state == LOAD_B ? n_b : n_a;
    base = state == LOAD_B ? b_base : a_base;
    ridx = IW'(r) * IW'(rn) + IW'(c);
    // r/c walk the result; source indices are derived from them per op
    ai = op == 3'd0 ? IW'(c) * IW'(a_n) + IW'(r) : op == 3'd3 ? IW'(r) * IW'(a_n) + IW'(k) : ridx;
    bi = op == 3'd3 ? IW'(k) * IW'(b_n) + IW'(c) : ridx;
    av = a_buf[ai];
    bv = b_buf[bi];
    ew = op == 3'd1 ? av + bv : op == 3'd2 ? av * scalar : op == 3'd4 ? av - bv : op == 3'd5 ? av * bv : av;
    store = state == CALC && (op != 3'd3 || k == a_n);
    store_val = op == 3'd3 ? acc : ew;
    last = r == rm - 1'b1 && c == rn - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (pv[RD_LAT-1] && ps[RD_LAT-1]) b_buf[pi[RD_LAT-1]] <= i_rd_data;
    if (pv[RD_LAT-1] && !ps[RD_LAT-1]) a_buf[pi[RD_LAT-1]] <= i_rd_data;
    if (store) res_buf[ridx] <= store_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op <= '0;
      a_base <= '0;
      b_base <= '0;
      r_base <= '0;
      a_m <= '0;
      a_n <= '0;
      b_m <= '0;
      b_n <= '0;
      scalar <= '0;
      acc <= '0;
      cnt <= '0;
      r <= '0;
      c <= '0;
      k <= '0;
      pv <= '0;
      ps <= '0;
      for (int i = 0; i < RD_LAT; i++) pi[i] <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_err <= '0;
      o_res_m <= '0;
      o_res_n <= '0;
      o_rd_en <= 1'b0;
      o_rd_addr <= '0;
      o_we <= 1'b0;
      o_waddr <= '0;
      o_wdata <= '0;
    end else begin
      // read data is steered by the request index carried alongside it
      pv[0] <= o_rd_en;
      ps[0] <= state == LOAD_B;
      pi[0] <= IW'(cnt);
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        ps[i] <= ps[i-1];
        pi[i] <= pi[i-1];
      end
      case (state)
        IDLE: if (i_start) begin
          state <= CHECK;
          o_busy <= 1'b1;
          o_err <= '0;
          o_res_m <= '0;
          o_res_n <= '0;
          op <= i_op;
          a_base <= i_a_addr;
          b_base <= i_b_addr;
          r_base <= i_res_addr;
          a_m <= i_a_m;
          a_n <= i_a_n;
          b_m <= i_b_m;
          b_n <= i_b_n;
          scalar <= i_scalar;
        end
        CHECK: if (err != 2'd0) begin
          state <= DONE;
          o_done <= 1'b1;
          o_busy <= 1'b0;
          o_err <= err;
        end else begin
          state <= LOAD_A;
          cnt <= '0;
          o_rd_en <= 1'b1;
          o_rd_addr <= a_base;
        end
        LOAD_A, LOAD_B: begin
          cnt <= cnt + 1'b1;
          o_rd_en <= cnt + 1'b1 < n_cur;
          o_rd_addr <= base + ADDR_W'(cnt + 1'b1);
          if (cnt == n_cur + LAT - 1'b1) begin
            cnt <= '0;
            r <= '0;
            c <= '0;
            k <= '0;
            acc <= '0;
            if (state == LOAD_A && uses_b) begin
              state <= LOAD_B;
              o_rd_en <= 1'b1;
              o_rd_addr <= b_base;
            end else begin
              state <= CALC;
              o_rd_en <= 1'b0;
            end
          end
        end
        CALC: if (store) begin
          acc <= '0;
          k <= '0;
          c <= c == rn - 1'b1 ? '0 : c + 1'b1;
          if (c == rn - 1'b1) r <= r + 1'b1;
          if (last) begin
            state <= WRITE;
            cnt <= '0;
            o_we <= 1'b1;
            o_waddr <= r_base;
            // a single-element result is stored on this same edge
            o_wdata <= ridx == '0 ? store_val : res_buf[0];
          end
        end else begin
          acc <= acc + av * bv;
          k <= k + 1'b1;
        end
        WRITE: begin
          cnt <= cnt + 1'b1;
          o_waddr <= r_base + ADDR_W'(cnt + 1'b1);
          o_wdata <= res_buf[IW'(cnt + 1'b1)];
          if (cnt == n_r - 1'b1) begin
            state <= DONE;
            o_we <= 1'b0;
            o_done <= 1'b1;
            o_busy <= 1'b0;
            o_res_m <= rm;
            o_res_n <= rn;
          end
        end
        DONE: begin
          o_done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_alu_engine.sv
// tb_matrix_alu_engine: table-driven runs with a write scoreboard, plus reset and ignored-start sequences.
module tb_matrix_alu_engine;
  localparam int DW = 32, AW = 8, MDIM = 5, LAT = 2, DIM_W = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  logic i_start = 1'b0;
  logic [2:0] i_op = '0;
  logic [AW-1:0] i_a_addr = '0, i_b_addr = '0, i_res_addr = '0;
  logic [DIM_W-1:0] i_a_m = '0, i_a_n = '0, i_b_m = '0, i_b_n = '0;
  logic [DW-1:0] i_scalar = '0;
  logic o_busy, o_done, o_rd_en, o_we;
  logic [1:0] o_err;
  logic [DIM_W-1:0] o_res_m, o_res_n;
  logic [AW-1:0] o_rd_addr, o_waddr;
  logic [DW-1:0] i_rd_data, o_wdata;

  always #5 clk = ~clk;

  matrix_alu_engine #(.DATA_W(DW), .ADDR_W(AW), .MAX_DIM(MDIM), .RD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_op(i_op),
    .i_a_addr(i_a_addr), .i_b_addr(i_b_addr), .i_res_addr(i_res_addr),
    .i_a_m(i_a_m), .i_a_n(i_a_n), .i_b_m(i_b_m), .i_b_n(i_b_n), .i_scalar(i_scalar),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_res_m(o_res_m), .o_res_n(o_res_n),
    .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
    .o_we(o_we), .o_waddr(o_waddr), .o_wdata(o_wdata)
  );

  logic [DW-1:0] mem [256];
  logic [LAT-1:0] rq_v = '0;
  logic [AW-1:0] rq_a [LAT];

  always @(posedge clk) begin
    rq_v[0] <= o_rd_en;
    rq_a[0] <= o_rd_addr;
    for (int i = 1; i < LAT; i++) begin
      rq_v[i] <= rq_v[i-1];
      rq_a[i] <= rq_a[i-1];
    end
  end
  assign i_rd_data = rq_v[LAT-1] ? mem[rq_a[LAT-1]] : '0;

  typedef struct {
    logic [2:0] op;
    int am, an, bm, bn;
    logic [7:0] aa, ba, ra;
    logic [31:0] a0, a_step, b0, b_step, sc, first;
    logic [1:0] err;
    int rm, rn;
  } vec_t;
  typedef struct { logic [7:0] addr; logic [31:0] data; } wr_t;

  wr_t exp_q[$];
  int checks = 0, errors = 0, rd_count = 0, wr_count = 0;
  logic [31:0] first_w;
  vec_t tv[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("rd_we_exclusive", {63'd0, o_rd_en & o_we}, 64'd0);
        if (o_rd_en) rd_count++;
        if (o_we) begin
          if (wr_count == 0) first_w = o_wdata;
          wr_count++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected no write", o_waddr, o_wdata);
          end else begin
            e = exp_q.pop_front();
            chk("waddr", o_waddr, e.addr);
            chk("wdata", o_wdata, e.data);
          end
        end
      end
    end
  endtask

  function automatic bit op_uses_b(input logic [2:0] op);
    return op == 3'd1 || op == 3'd3 || op == 3'd4 || op == 3'd5;
  endfunction

  task automatic load_and_model(input vec_t v);
    logic [31:0] A [25];
    logic [31:0] B [25];
    logic [31:0] R;
    logic [7:0] ad;
    wr_t w;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    if (v.err != 2'd0) return;
    for (int i = 0; i < v.am * v.an; i++) begin
      A[i] = v.a0 + v.a_step * i;
      ad = v.aa + 8'(i);
      mem[ad] = A[i];
    end
    if (op_uses_b(v.op))
      for (int i = 0; i < v.bm * v.bn; i++) begin
        B[i] = v.b0 + v.b_step * i;
        ad = v.ba + 8'(i);
        mem[ad] = B[i];
      end
    for (int i = 0; i < v.rm; i++)
      for (int j = 0; j < v.rn; j++) begin
        case (v.op)
          3'd0: R = A[j*v.an + i];
          3'd1: R = A[i*v.an + j] + B[i*v.an + j];
          3'd2: R = A[i*v.an + j] * v.sc;
          3'd4: R = A[i*v.an + j] - B[i*v.an + j];
          3'd5: R = A[i*v.an + j] * B[i*v.an + j];
          default: begin
            R = '0;
            for (int q = 0; q < v.an; q++) R = R + A[i*v.an + q] * B[q*v.bn + j];
          end
        endcase
        w.addr = v.ra + 8'(i*v.rn + j);
        w.data = R;
        exp_q.push_back(w);
      end
  endtask

  task automatic run(input vec_t v, input string tag);
    int n, na, nb, nr, calc, exp_done;
    bit ub;
    load_and_model(v);
    rd_count = 0;
    wr_count = 0;
    ub = op_uses_b(v.op);
    na = v.am * v.an;
    nb = v.bm * v.bn;
    nr = v.rm * v.rn;
    calc = v.op == 3'd3 ? nr * (v.an + 1) : nr;
    exp_done = v.err != 2'd0 ? 2 : 2 + na + LAT + (ub ? nb + LAT : 0) + calc + nr;
    @(negedge clk);
    i_op = v.op; i_a_addr = v.aa; i_b_addr = v.ba; i_res_addr = v.ra; i_scalar = v.sc;
    i_a_m = 3'(v.am); i_a_n = 3'(v.an); i_b_m = 3'(v.bm); i_b_n = 3'(v.bn);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_op = 3'd6; i_a_m = '0; i_a_n = 3'd7; i_a_addr = 8'hEE; i_res_addr = 8'hEE; i_scalar = '1;
    n = 1;
    chk({tag, " busy_cycle1"}, o_busy, 1);
    while (!o_done && n < 3000) begin
      @(negedge clk);
      n++;
      if (n == 3) begin i_start = 1'b1; i_op = 3'd1; i_a_m = 3'd1; i_a_n = 3'd1; end
      if (n == 4) i_start = 1'b0;
    end
    chk({tag, " done"}, o_done, 1);
    chk({tag, " done_cycle"}, n, exp_done);
    chk({tag, " err"}, o_err, v.err);
    chk({tag, " res_m"}, o_res_m, v.rm);
    chk({tag, " res_n"}, o_res_n, v.rn);
    chk({tag, " busy_at_done"}, o_busy, 0);
    chk({tag, " reads"}, rd_count, v.err != 2'd0 ? 0 : na + (ub ? nb : 0));
    chk({tag, " writes"}, wr_count, v.err != 2'd0 ? 0 : nr);
    chk({tag, " pending"}, exp_q.size(), 0);
    if (v.err == 2'd0) chk({tag, " first_word"}, first_w, v.first);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk({tag, " done_pulse"}, o_done, 0);
    chk({tag, " start_at_done_ignored"}, o_busy, 0);
    @(negedge clk);
    chk({tag, " idle_after"}, o_busy, 0);
    exp_q.delete();
  endtask

  initial begin
    int n;
    //        op    am an bm bn  aa     ba     ra     a0            a_step b0            b_step sc     first          err rm rn
    tv[0]  = '{3'd1, 2, 2, 2, 2, 8'h10, 8'h20, 8'h30, 32'd1,        1, 32'd10,        10, 32'd0, 32'd11,         2'd0, 2, 2};
    tv[1]  = '{3'd3, 2, 3, 3, 2, 8'h40, 8'h50, 8'h60, 32'd1,        1, 32'd7,         1,  32'd0, 32'd58,         2'd0, 2, 2};
    tv[2]  = '{3'd0, 2, 3, 0, 0, 8'h10, 8'h20, 8'h30, 32'd1,        1, 32'd0,         0,  32'd0, 32'd1,          2'd0, 3, 2};
    tv[3]  = '{3'd4, 1, 1, 1, 1, 8'h70, 8'h71, 8'h72, 32'd0,        0, 32'd1,         0,  32'd0, 32'hFFFFFFFF,   2'd0, 1, 1};
    tv[4]  = '{3'd2, 1, 1, 0, 0, 8'h80, 8'h90, 8'h74, 32'h80000000, 0, 32'd0,         0,  32'd2, 32'd0,          2'd0, 1, 1};
    tv[5]  = '{3'd1, 1, 2, 1, 2, 8'hFF, 8'h8C, 8'hFF, 32'd5,        1, 32'd100,       1,  32'd0, 32'd105,        2'd0, 1, 2};
    tv[6]  = '{3'd5, 2, 2, 2, 2, 8'h20, 8'h28, 8'h30, 32'd3,        1, 32'hFFFFFFFE,  1,  32'd0, 32'hFFFFFFFA,   2'd0, 2, 2};
    tv[7]  = '{3'd3, 3, 1, 1, 2, 8'h08, 8'h18, 8'h28, 32'd2,        1, 32'd5,         1,  32'd0, 32'd10,         2'd0, 3, 2};
    tv[8]  = '{3'd7, 0, 2, 2, 2, 8'h00, 8'h00, 8'h00, 32'd0,        0, 32'd0,         0,  32'd0, 32'd0,          2'd1, 0, 0};
    tv[9]  = '{3'd1, 6, 2, 6, 2, 8'h00, 8'h40, 8'h80, 32'd0,        0, 32'd0,         0,  32'd0, 32'd0,          2'd2, 0, 0};
    tv[10] = '{3'd1, 2, 2, 2, 3, 8'h00, 8'h40, 8'h80, 32'd0,        0, 32'd0,         0,  32'd0, 32'd0,          2'd3, 0, 0};
    tv[11] = '{3'd3, 2, 2, 2, 0, 8'h00, 8'h40, 8'h80, 32'd0,        0, 32'd0,         0,  32'd0, 32'd0,          2'd2, 0, 0};
    tv[12] = '{3'd0, 1, 3, 7, 0, 8'h30, 8'h40, 8'h50, 32'd9,        1, 32'd0,         0,  32'd0, 32'd9,          2'd0, 3, 1};
    tv[13] = '{3'd3, 2, 2, 3, 2, 8'h00, 8'h40, 8'h80, 32'd0,        0, 32'd0,         0,  32'd0, 32'd0,          2'd3, 0, 0};
    tv[14] = '{3'd3, 5, 5, 5, 5, 8'h00, 8'h40, 8'h80, 32'd1,        1, 32'd1,         0,  32'd0, 32'd15,         2'd0, 5, 5};
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    chk("reset busy", o_busy, 0);
    chk("reset done", o_done, 0);
    chk("reset err", o_err, 0);
    chk("reset rd_en", o_rd_en, 0);
    chk("reset we", o_we, 0);
    chk("reset wdata", o_wdata, 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 15; i++) run(tv[i], $sformatf("vec%0d", i));
    load_and_model(tv[0]);
    wr_count = 0;
    @(negedge clk);
    i_op = tv[0].op; i_a_addr = tv[0].aa; i_b_addr = tv[0].ba; i_res_addr = tv[0].ra;
    i_a_m = 3'd2; i_a_n = 3'd2; i_b_m = 3'd2; i_b_n = 3'd2;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    n = 0;
    while (!o_we && n < 100) begin @(negedge clk); n++; end
    chk("rst write_reached", o_we, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst we", o_we, 0);
    chk("rst rd_en", o_rd_en, 0);
    chk("rst busy", o_busy, 0);
    chk("rst done", o_done, 0);
    chk("rst waddr", o_waddr, 0);
    chk("rst wdata", o_wdata, 0);
    chk("rst res_m", o_res_m, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_rst we", o_we, 0);
    chk("post_rst busy", o_busy, 0);
    chk("post_rst writes", wr_count, 1);
    run(tv[1], "after_reset");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
